alu_mcycle: RTL and testbench

Parametrised, registered successor to the single-cycle datapath ALU. It executes the eight ARM data-processing operations in one cycle and iterative multiply and divide over multiple cycles, behind a Start/Busy/Done handshake. Results and NZCV flags are registered and held until the next completion. It sits in the execute stage; the control unit stalls the pipeline while Busy is high.

---
 rtl/alu_mcycle.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_alu_mcycle.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mcycle.sv
// Registered execute-stage ALU: single-cycle ARM data-processing ops plus
// iterative shift-add multiply and restoring divide behind Start/Busy/Done.
module alu_mcycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic             Signed,
  input  logic             Carry,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       ALUFlags,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_ADC = 4'b0100;
  localparam logic [3:0] OP_EOR = 4'b0101;
  localparam logic [3:0] OP_BIC = 4'b0110;
  localparam logic [3:0] OP_SBC = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             op_div_q, op_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result2_q, result2_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_mc;
  logic             accept_sc;
  logic             accept_mc;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_mc     = (ALUControl[3:1] == 3'b100);
  assign accept_sc = (state_q == S_IDLE) && Start && !is_mc;
  assign accept_mc = (state_q == S_IDLE) && Start && is_mc;
  assign a_mag     = (Signed && Src_A[WIDTH-1]) ? -Src_A : Src_A;
  assign b_mag     = (Signed && Src_B[WIDTH-1]) ? -Src_B : Src_B;

  // Single-cycle datapath: shared WIDTH+1-bit adder for the four arithmetic ops
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             is_sub;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;

  assign sum = {1'b0, Src_A} + {1'b0, b_eff} + SUM_W'(cin);

  always_comb begin
    b_eff  = Src_B;
    cin    = 1'b0;
    is_sub = 1'b0;
    case (ALUControl)
      OP_SUB: begin
        b_eff  = ~Src_B;
        cin    = 1'b1;
        is_sub = 1'b1;
      end
      OP_ADC: cin = Carry;
      OP_SBC: begin
        b_eff  = ~Src_B;
        cin    = Carry;
        is_sub = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sc_res = Src_B;
    sc_c   = Carry;
    sc_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        if (is_sub) begin
          sc_v = (Src_A[WIDTH-1] ^ Src_B[WIDTH-1]) & (Src_A[WIDTH-1] ^ sum[WIDTH-1]);
        end else begin
          sc_v = (Src_A[WIDTH-1] ~^ Src_B[WIDTH-1]) & (Src_A[WIDTH-1] ^ sum[WIDTH-1]);
        end
      end
      OP_AND: sc_res = Src_A & Src_B;
      OP_ORR: sc_res = Src_A | Src_B;
      OP_EOR: sc_res = Src_A ^ Src_B;
      OP_BIC: sc_res = Src_A & ~Src_B;
      default: ;
    endcase
  end

  // Iteration step: hi/lo hold product halves for MUL, remainder/quotient for DIV
  logic [SUM_W-1:0] mul_sum;
  logic [SUM_W-1:0] div_shift;
  logic [SUM_W-1:0] div_trial;

  assign mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Sign correction applied in FIX
  logic [PROD_W-1:0] prod_raw;
  logic [PROD_W-1:0] prod_fix;
  logic [WIDTH-1:0]  quo_fix;
  logic [WIDTH-1:0]  rem_fix;
  logic [WIDTH-1:0]  fix_res;
  logic [WIDTH-1:0]  fix_res2;

  assign prod_raw = {hi_q, lo_q};
  assign prod_fix = neg_res_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_res_q ? -lo_q : lo_q;
  assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

  always_comb begin
    fix_res  = prod_fix[WIDTH-1:0];
    fix_res2 = prod_fix[PROD_W-1:WIDTH];
    if (op_div_q) begin
      if (div_zero_q) begin
        fix_res  = '1;
        fix_res2 = a_raw_q;
      end else begin
        fix_res  = quo_fix;
        fix_res2 = rem_fix;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_mc) state_d = S_BUSY;
      S_BUSY: if (cnt_q == LAST_CNT) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    op_div_d   = op_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    result_d   = result_q;
    result2_d  = result2_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept_sc) begin
          result_d  = sc_res;
          result2_d = '0;
          flags_d   = {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
          done_d    = 1'b1;
        end else if (accept_mc) begin
          op_div_d   = ALUControl[0];
          neg_res_d  = Signed && (Src_A[WIDTH-1] ^ Src_B[WIDTH-1]);
          neg_rem_d  = Signed && Src_A[WIDTH-1];
          div_zero_d = (Src_B == '0);
          a_raw_d    = Src_A;
          cnt_d      = '0;
          hi_d       = '0;
          opnd_d     = ALUControl[0] ? b_mag : a_mag;
          lo_d       = ALUControl[0] ? a_mag : b_mag;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_div_q) begin
          if (!div_trial[WIDTH]) begin
            hi_d = div_trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else if (lo_q[0]) begin
          {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        result_d  = fix_res;
        result2_d = fix_res2;
        flags_d   = {fix_res[WIDTH-1], (fix_res == '0), 2'b00};
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
      result2_q  <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      op_div_q   <= op_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
      result2_q  <= result2_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Result   = result_q;
  assign Result2  = result2_q;
  assign ALUFlags = flags_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_alu_mcycle.sv
// Scoreboard bench for alu_mcycle: the driver queues expected results, the
// monitor pops and compares on every Done pulse.
module tb_alu_mcycle;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          Start;
  logic [3:0]    ALUControl;
  logic          Signed;
  logic          Carry;
  logic [W-1:0]  Src_A;
  logic [W-1:0]  Src_B;
  logic [W-1:0]  Result;
  logic [W-1:0]  Result2;
  logic [3:0]    ALUFlags;
  logic          Busy;
  logic          Done;

  alu_mcycle #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .ALUControl(ALUControl),
    .Signed(Signed), .Carry(Carry), .Src_A(Src_A), .Src_B(Src_B),
    .Result(Result), .Result2(Result2), .ALUFlags(ALUFlags),
    .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] r2;
    logic [3:0]   f;
    int           acc;
    bit           mc;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   next_id = 0;
  int   busy_run  = 0;
  int   busy_last = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s op#%0d: got 0x%0h, expected 0x%0h", nm, id, act, exp);
    end
  endtask

  // Monitor: compare whenever the DUT presents a completion
  exp_t m;
  always begin
    @(negedge CLK);
    if (Busy) busy_run++;
    else begin
      if (busy_run != 0) busy_last = busy_run;
      busy_run = 0;
    end
    if (Done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: got Done=1, expected no completion", cyc);
      end else begin
        m = sb.pop_front();
        chk("result",    m.id, 64'(Result),   64'(m.r));
        chk("result2",   m.id, 64'(Result2),  64'(m.r2));
        chk("nzcv",      m.id, 64'(ALUFlags), 64'(m.f));
        chk("busy_done", m.id, 64'(Busy),     64'(0));
        chk("latency",   m.id, 64'(cyc - m.acc), 64'(m.mc ? W + 1 : 0));
        if (m.mc) chk("busy_cycles", m.id, 64'(busy_last), 64'(W + 1));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic sg, input logic cy,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [W-1:0] er2,
                       input logic [3:0] ef, input bit hold);
    exp_t e;
    ALUControl = op;
    Signed     = sg;
    Carry      = cy;
    Src_A      = a;
    Src_B      = b;
    Start      = 1'b1;
    e.r   = er;
    e.r2  = er2;
    e.f   = ef;
    e.acc = cyc + 1;
    e.mc  = (op[3:1] == 3'b100);
    e.id  = next_id;
    next_id++;
    sb.push_back(e);
    @(negedge CLK);
    if (!hold) Start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_result"},  -1, 64'(Result),   64'(0));
    chk({nm, "_result2"}, -1, 64'(Result2),  64'(0));
    chk({nm, "_flags"},   -1, 64'(ALUFlags), 64'(0));
    chk({nm, "_busy"},    -1, 64'(Busy),     64'(0));
    chk({nm, "_done"},    -1, 64'(Done),     64'(0));
  endtask

  initial begin
    RESET = 1'b1; Start = 1'b0; ALUControl = 4'd0; Signed = 1'b0; Carry = 1'b0;
    Src_A = '0; Src_B = '0;
    repeat (2) @(negedge CLK);
    chk_reset_outputs("por");
    RESET = 1'b0;
    @(negedge CLK);

    // Single-cycle ops
    issue(4'b0000, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'b1001, 0);
    drain();
    issue(4'b0001, 0, 0, 32'd5, 32'd5, 32'h0, 32'h0, 4'b0110, 0);
    drain();
    issue(4'b0111, 0, 0, 32'd5, 32'd5, 32'hFFFFFFFF, 32'h0, 4'b1000, 0);
    drain();
    issue(4'b0100, 0, 1, 32'd1, 32'd2, 32'd4, 32'h0, 4'b0000, 0);
    drain();
    issue(4'b0011, 0, 1, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 32'h0, 4'b0010, 0);
    drain();
    issue(4'b0101, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 4'b0100, 0);
    drain();
    issue(4'b0110, 0, 1, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 4'b1010, 0);
    drain();
    issue(4'b1111, 0, 0, 32'h12345678, 32'h80000001, 32'h80000001, 32'h0, 4'b1000, 0);
    drain();

    // Multiply
    issue(4'b1000, 1, 0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 4'b1000, 0);
    drain();
    issue(4'b1000, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b0000, 0);
    drain();

    // Divide
    issue(4'b1001, 0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 0);
    drain();
    issue(4'b1001, 1, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 0);
    drain();
    issue(4'b1001, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 4'b1000, 0);
    drain();
    issue(4'b1001, 0, 0, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 4'b1000, 0);
    drain();
    issue(4'b1001, 1, 0, 32'hFFFFFF00, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF00, 4'b1000, 0);
    drain();

    // Start during Busy is ignored; Start on the Done cycle is accepted
    issue(4'b1001, 1, 0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 4'b1000, 0);
    repeat (3) @(negedge CLK);
    ALUControl = 4'b0000; Signed = 1'b0; Src_A = 32'd1; Src_B = 32'd2; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    for (int i = 0; i < 100 && !Done; i++) @(negedge CLK);
    issue(4'b0001, 0, 0, 32'd10, 32'd3, 32'd7, 32'h0, 4'b0010, 0);
    drain();

    // Back-to-back single-cycle ops with Start held
    issue(4'b0000, 0, 0, 32'd1, 32'd1, 32'd2, 32'h0, 4'b0000, 1);
    issue(4'b0010, 0, 0, 32'hF, 32'd3, 32'd3, 32'h0, 4'b0000, 1);
    issue(4'b0101, 0, 0, 32'd1, 32'd1, 32'd0, 32'h0, 4'b0100, 1);
    issue(4'b0001, 0, 0, 32'd3, 32'd5, 32'hFFFFFFFE, 32'h0, 4'b1000, 0);
    drain();

    // Reset in the middle of a multiply discards it
    issue(4'b1000, 0, 0, 32'd7, 32'd6, 32'd42, 32'h0, 4'b0000, 0);
    repeat (8) @(negedge CLK);
    RESET = 1'b1;
    sb.delete();
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge CLK);
    RESET = 1'b0;
    repeat (40) @(negedge CLK);
    issue(4'b1000, 1, 0, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 32'hFFFFFFFF, 4'b1000, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1);
  end

endmodule
